// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA modular-exponentiation controller.
package rsa_ctrl_pkg;

  localparam int unsigned MM_OPW = 2;

  localparam logic [MM_OPW-1:0] OP_TO_MONT   = MM_OPW'(0);
  localparam logic [MM_OPW-1:0] OP_SQR       = MM_OPW'(1);
  localparam logic [MM_OPW-1:0] OP_MUL       = MM_OPW'(2);
  localparam logic [MM_OPW-1:0] OP_FROM_MONT = MM_OPW'(3);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    CONV  = 3'd2,
    SQR   = 3'd3,
    MUL   = 3'd4,
    FINAL = 3'd5,
    DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/exp_scan.sv
// Exponent holder and MSB-first bit scanner for the square-and-multiply loop.
module exp_scan #(
  parameter int unsigned EXP_W = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             init_idx,
  input  logic             dec,
  output logic             cur_bit_c,
  output logic             last_c
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    exp_d = exp_q;
    idx_d = idx_q;
    if (capture) exp_d = exp_in;
    if (init_idx) begin
      idx_d = IDX_W'(EXP_W - 1);
    end else if (dec && (idx_q != '0)) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      idx_q <= '0;
    end else begin
      exp_q <= exp_d;
      idx_q <= idx_d;
    end
  end

  assign cur_bit_c = exp_q[idx_q];
  assign last_c    = (idx_q == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Sequencer for Montgomery-domain left-to-right square-and-multiply exponentiation.
module modexp_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned EXP_W  = 1024,
  parameter int unsigned MM_OPW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [EXP_W-1:0]  exp,
  output logic              pre_start,
  input  logic              n0p_done,
  input  logic              rt_done,
  output logic              mm_start,
  output logic [MM_OPW-1:0] mm_op,
  output logic              acc_load_r,
  input  logic              mm_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic              n0p_q, n0p_d;
  logic              rt_q, rt_d;
  logic              pre_start_q, pre_start_d;
  logic              mm_start_q, mm_start_d;
  logic [MM_OPW-1:0] mm_op_q, mm_op_d;
  logic              acc_load_r_q, acc_load_r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic capture, init_idx, dec;
  logic cur_bit_c, last_c;
  logic wait_c, mm_ack_c;

  exp_scan #(.EXP_W(EXP_W)) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .exp_in    (exp),
    .init_idx  (init_idx),
    .dec       (dec),
    .cur_bit_c (cur_bit_c),
    .last_c    (last_c)
  );

  // A multiplier op is outstanding in any mm state once its launch cycle has passed.
  assign wait_c   = ((state_q == CONV) || (state_q == SQR) || (state_q == MUL) ||
                     (state_q == FINAL)) && !mm_start_q;
  assign mm_ack_c = wait_c && mm_done;

  always_comb begin
    state_d      = state_q;
    n0p_d        = n0p_q;
    rt_d         = rt_q;
    pre_start_d  = 1'b0;
    mm_start_d   = 1'b0;
    mm_op_d      = mm_op_q;
    acc_load_r_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    capture      = 1'b0;
    init_idx     = 1'b0;
    dec          = 1'b0;

    if (mm_done && !wait_c) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture     = 1'b1;
          n0p_d       = 1'b0;
          rt_d        = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          pre_start_d = 1'b1;
          state_d     = PRE;
        end
      end
      PRE: begin
        n0p_d = n0p_q | n0p_done;
        rt_d  = rt_q | rt_done;
        if (n0p_d && rt_d) begin
          state_d      = CONV;
          mm_start_d   = 1'b1;
          mm_op_d      = MM_OPW'(OP_TO_MONT);
          acc_load_r_d = 1'b1;
          init_idx     = 1'b1;
        end
      end
      CONV: begin
        if (mm_ack_c) begin
          state_d    = SQR;
          mm_start_d = 1'b1;
          mm_op_d    = MM_OPW'(OP_SQR);
        end
      end
      SQR: begin
        if (mm_ack_c) begin
          mm_start_d = 1'b1;
          if (cur_bit_c) begin
            state_d = MUL;
            mm_op_d = MM_OPW'(OP_MUL);
          end else if (!last_c) begin
            dec     = 1'b1;
            state_d = SQR;
            mm_op_d = MM_OPW'(OP_SQR);
          end else begin
            state_d = FINAL;
            mm_op_d = MM_OPW'(OP_FROM_MONT);
          end
        end
      end
      MUL: begin
        if (mm_ack_c) begin
          mm_start_d = 1'b1;
          if (!last_c) begin
            dec     = 1'b1;
            state_d = SQR;
            mm_op_d = MM_OPW'(OP_SQR);
          end else begin
            state_d = FINAL;
            mm_op_d = MM_OPW'(OP_FROM_MONT);
          end
        end
      end
      FINAL: begin
        if (mm_ack_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Cancel overrides every transition, including a coincident completion.
    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      pre_start_d  = 1'b0;
      mm_start_d   = 1'b0;
      acc_load_r_d = 1'b0;
      done_d       = 1'b0;
      init_idx     = 1'b0;
      dec          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n0p_q        <= 1'b0;
      rt_q         <= 1'b0;
      pre_start_q  <= 1'b0;
      mm_start_q   <= 1'b0;
      mm_op_q      <= '0;
      acc_load_r_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n0p_q        <= n0p_d;
      rt_q         <= rt_d;
      pre_start_q  <= pre_start_d;
      mm_start_q   <= mm_start_d;
      mm_op_q      <= mm_op_d;
      acc_load_r_q <= acc_load_r_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign pre_start  = pre_start_q;
  assign mm_start   = mm_start_q;
  assign mm_op      = mm_op_q;
  assign acc_load_r = acc_load_r_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with EXP_W=4 and a 3-cycle multiplier model.
module tb_modexp_ctrl;

  localparam int unsigned EXP_W  = 4;
  localparam int unsigned MM_OPW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [EXP_W-1:0]  exp_v = '0;
  logic              pre_start;
  logic              n0p_done = 1'b0;
  logic              rt_done = 1'b0;
  logic              mm_start;
  logic [MM_OPW-1:0] mm_op;
  logic              acc_load_r;
  logic              mm_done;
  logic              busy;
  logic              done;
  logic              err;
  logic              stray_done = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  modexp_ctrl #(.EXP_W(EXP_W), .MM_OPW(MM_OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .exp        (exp_v),
    .pre_start  (pre_start),
    .n0p_done   (n0p_done),
    .rt_done    (rt_done),
    .mm_start   (mm_start),
    .mm_op      (mm_op),
    .acc_load_r (acc_load_r),
    .mm_done    (mm_done),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Multiplier model: completion pulse three cycles after the launch cycle.
  int mdl_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl_cnt <= 0;
    else if (mm_start) mdl_cnt <= 3;
    else if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
  end
  assign mm_done = (mdl_cnt == 1) || stray_done;

  // Observation log: op codes are shifted in two bits at a time.
  bit [63:0] seq_code = '0;
  int op_n = 0;
  int done_n = 0;
  int pre_n = 0;
  always @(negedge clk) begin
    if (mm_start) begin
      seq_code <= {seq_code[61:0], 2'(mm_op)};
      op_n <= op_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (pre_start) pre_n <= pre_n + 1;
  end

  function automatic bit [63:0] seq_since(input int base);
    int n;
    n = op_n - base;
    return seq_code & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [EXP_W-1:0] e);
    exp_v = e;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic fire_both();
    n0p_done = 1'b1;
    rt_done  = 1'b1;
    cyc(1);
    n0p_done = 1'b0;
    rt_done  = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && done !== 1'b1; k++) cyc(1);
  endtask

  task automatic wait_ops(input int base, input int n);
    for (int k = 0; k < 200 && (op_n - base) < n; k++) cyc(1);
  endtask

  task automatic test_reset();
    cyc(2);
    tests_run++;
    if ({pre_start, mm_start, mm_op, acc_load_r, busy, done, err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0",
               {pre_start, mm_start, mm_op, acc_load_r, busy, done, err});
    end
    rst_n = 1'b1;
    cyc(2);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int b, d, p;
    b = op_n; d = done_n; p = pre_n;
    launch(4'b1011);
    tests_run++;
    if (pre_start !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_launch: got pre_start=%b busy=%b expected 1 1", pre_start, busy);
    end
    cyc(4); n0p_done = 1'b1; cyc(1); n0p_done = 1'b0;
    cyc(2); rt_done = 1'b1;  cyc(1); rt_done = 1'b0;
    wait_done();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_cycle: got done=%b busy=%b expected 1 0", done, busy);
    end
    cyc(1);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_width: got %b expected 0", done);
    end
    cyc(3);
    tests_run++;
    if (op_n - b != 9 || seq_since(b) !== 64'(18'b00_01_10_01_01_10_01_10_11)) begin
      tests_failed++;
      $display("FAIL basic_seq: got n=%0d code=%0h expected n=9 code=%0h",
               op_n - b, seq_since(b), 64'(18'b00_01_10_01_01_10_01_10_11));
    end
    tests_run++;
    if (done_n - d != 1 || pre_n - p != 1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_counts: got done=%0d pre=%0d err=%b expected 1 1 0",
               done_n - d, pre_n - p, err);
    end
  endtask

  task automatic test_zero_exp();
    int b, d;
    b = op_n; d = done_n;
    launch(4'b0000);
    fire_both();
    wait_done();
    cyc(3);
    tests_run++;
    if (op_n - b != 6 || seq_since(b) !== 64'(12'b00_01_01_01_01_11) || done_n - d != 1) begin
      tests_failed++;
      $display("FAIL zero_exp_seq: got n=%0d code=%0h done=%0d expected n=6 code=%0h done=1",
               op_n - b, seq_since(b), done_n - d, 64'(12'b00_01_01_01_01_11));
    end
  endtask

  task automatic test_pre_flags();
    int b;
    b = op_n;
    launch(4'b0001);
    cyc(1); n0p_done = 1'b1; cyc(1); n0p_done = 1'b0;
    cyc(2); n0p_done = 1'b1; cyc(1); n0p_done = 1'b0;
    cyc(4);
    tests_run++;
    if (op_n - b != 0 || busy !== 1'b1 || mm_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_hold: got ops=%0d busy=%b mm_start=%b expected 0 1 0",
               op_n - b, busy, mm_start);
    end
    rt_done = 1'b1; cyc(1); rt_done = 1'b0;
    tests_run++;
    if (mm_start !== 1'b1 || mm_op !== 2'd0 || acc_load_r !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_release: got mm_start=%b op=%0d acc_load_r=%b expected 1 0 1",
               mm_start, mm_op, acc_load_r);
    end
    wait_done();
    cyc(2);
    tests_run++;
    if (op_n - b != 7 || seq_since(b) !== 64'(14'b00_01_01_01_01_10_11)) begin
      tests_failed++;
      $display("FAIL pre_seq: got n=%0d code=%0h expected n=7 code=%0h",
               op_n - b, seq_since(b), 64'(14'b00_01_01_01_01_10_11));
    end
  endtask

  task automatic test_same_cycle();
    int b;
    b = op_n;
    launch(4'b0110);
    cyc(2);
    fire_both();
    tests_run++;
    if (mm_start !== 1'b1 || mm_op !== 2'd0 || acc_load_r !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_conv: got mm_start=%b op=%0d acc_load_r=%b expected 1 0 1",
               mm_start, mm_op, acc_load_r);
    end
    cyc(1);
    tests_run++;
    if (mm_start !== 1'b0 || acc_load_r !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_strobe: got mm_start=%b acc_load_r=%b expected 0 0",
               mm_start, acc_load_r);
    end
    wait_done();
    cyc(2);
    tests_run++;
    if (op_n - b != 8 || seq_since(b) !== 64'(16'b00_01_01_10_01_10_01_11)) begin
      tests_failed++;
      $display("FAIL same_cycle_seq: got n=%0d code=%0h expected n=8 code=%0h",
               op_n - b, seq_since(b), 64'(16'b00_01_01_10_01_10_01_11));
    end
  endtask

  task automatic test_abort();
    int b, d;
    b = op_n; d = done_n;
    launch(4'b1011);
    fire_both();
    wait_ops(b, 4);
    abort = 1'b1; cyc(1); abort = 1'b0;
    tests_run++;
    if ({busy, mm_start, pre_start, acc_load_r} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy/mm_start/pre_start/acc=%b expected 0000",
               {busy, mm_start, pre_start, acc_load_r});
    end
    cyc(2);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_late_done_err: got %b expected 1", err);
    end
    cyc(5);
    tests_run++;
    if (done_n - d != 0 || op_n - b != 4) begin
      tests_failed++;
      $display("FAIL abort_no_done: got done=%0d ops=%0d expected 0 4", done_n - d, op_n - b);
    end
    b = op_n;
    launch(4'b1011);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_err_clear: got %b expected 0", err);
    end
    fire_both();
    wait_done();
    cyc(2);
    tests_run++;
    if (op_n - b != 9 || seq_since(b) !== 64'(18'b00_01_10_01_01_10_01_10_11)) begin
      tests_failed++;
      $display("FAIL abort_rerun_seq: got n=%0d code=%0h expected n=9 code=%0h",
               op_n - b, seq_since(b), 64'(18'b00_01_10_01_01_10_01_10_11));
    end
  endtask

  task automatic test_start_ignored();
    int b, p;
    b = op_n; p = pre_n;
    launch(4'b1011);
    fire_both();
    wait_ops(b, 3);
    exp_v = 4'b0000; start = 1'b1; cyc(1); start = 1'b0;
    wait_done();
    cyc(2);
    tests_run++;
    if (op_n - b != 9 || seq_since(b) !== 64'(18'b00_01_10_01_01_10_01_10_11) || pre_n - p != 1) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: got n=%0d code=%0h pre=%0d expected n=9 code=%0h pre=1",
               op_n - b, seq_since(b), pre_n - p, 64'(18'b00_01_10_01_01_10_01_10_11));
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_err_before_stray: got %b expected 0", err);
    end
    stray_done = 1'b1; cyc(1); stray_done = 1'b0;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_stray_err: got %b expected 1", err);
    end
  endtask

  task automatic test_reset_mid();
    int b, d;
    b = op_n; d = done_n;
    launch(4'b1011);
    fire_both();
    wait_ops(b, 3);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pre_start, mm_start, mm_op, acc_load_r, busy, done, err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got %b expected 0",
               {pre_start, mm_start, mm_op, acc_load_r, busy, done, err});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    tests_run++;
    if (done_n - d != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got %0d expected 0", done_n - d);
    end
    b = op_n; d = done_n;
    launch(4'b1000);
    fire_both();
    wait_done();
    cyc(2);
    tests_run++;
    if (op_n - b != 7 || seq_since(b) !== 64'(14'b00_01_10_01_01_01_11) ||
        done_n - d != 1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rerun_seq: got n=%0d code=%0h done=%0d err=%b expected n=7 code=%0h done=1 err=0",
               op_n - b, seq_since(b), done_n - d, err, 64'(14'b00_01_10_01_01_01_11));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_exp();
    test_pre_flags();
    test_same_cycle();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
